// File: rtl/cpu_player_pkg.sv
// Shared types and default sizing for the automated key-press player.
package cpu_player_pkg;

  localparam int DEFAULT_WIDTH    = 10;
  localparam int DEFAULT_COOLDOWN = 3;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    DECIDE,
    PRESS,
    COOL
  } state_t;

endpackage

// File: rtl/cpu_player.sv
// Gathers WIDTH serial random bits, presses for one cycle when the sample is below level, then cools down.
// press rises WIDTH+1 edges after enable is taken in IDLE; dropping enable aborts only during FILL.
module cpu_player
  import cpu_player_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int COOLDOWN = DEFAULT_COOLDOWN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             rnd_bit,
  input  logic [WIDTH-1:0] level,
  output logic             press,
  output logic             busy,
  output logic [WIDTH-1:0] sample
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    bit_cnt;
  logic [3:0]       cool_cnt;
  logic [WIDTH-1:0] shreg;
  logic             fill_last;
  logic             cool_last;

  assign fill_last = (bit_cnt == CW'(WIDTH - 1));
  assign cool_last = (cool_cnt == 4'd1);

  // Outputs decode straight from the state register, so they are glitch-free and reset with it.
  assign press = (state == PRESS);
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (enable) state_nxt = FILL;
      end
      FILL: begin
        if (!enable)        state_nxt = IDLE;
        else if (fill_last) state_nxt = DECIDE;
      end
      DECIDE: begin
        state_nxt = (shreg < level) ? PRESS : COOL;
      end
      PRESS: begin
        state_nxt = COOL;
      end
      COOL: begin
        if (cool_last) state_nxt = enable ? FILL : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt  <= '0;
      cool_cnt <= '0;
      shreg    <= '0;
      sample   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            bit_cnt <= '0;
            shreg   <= '0;
          end
        end
        FILL: begin
          if (enable) begin
            shreg   <= {shreg[WIDTH-2:0], rnd_bit};
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        DECIDE: begin
          sample   <= shreg;
          cool_cnt <= 4'(COOLDOWN);
        end
        COOL: begin
          cool_cnt <= cool_cnt - 4'd1;
          if (cool_last) begin
            bit_cnt <= '0;
            shreg   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_player.sv
// Randomised and directed checks of cpu_player against a run-position reference model.
module tb_cpu_player;

  localparam int W = 10;
  localparam int C = 3;

  logic         clk;
  logic         reset;
  logic         enable;
  logic         rnd_bit;
  logic [W-1:0] level;
  logic         press;
  logic         busy;
  logic [W-1:0] sample;

  cpu_player #(.WIDTH(W), .COOLDOWN(C)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .rnd_bit(rnd_bit),
    .level  (level),
    .press  (press),
    .busy   (busy),
    .sample (sample)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Reference model: a run is a timeline of positions since the run began.
  // Positions 0..W-1 collect bits, W decides, W+1 presses (if taken), then C cool positions.
  bit m_act = 1'b0;
  int m_pos = 0;
  int m_val = 0;
  bit m_prs = 1'b0;
  int m_smp = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_act = 1'b0; m_pos = 0; m_val = 0; m_prs = 1'b0; m_smp = 0;
    end else if (!m_act) begin
      if (enable) begin
        m_act = 1'b1; m_pos = 0; m_val = 0;
      end
    end else if (m_pos < W) begin
      if (!enable) begin
        m_act = 1'b0;
      end else begin
        m_val = m_val * 2 + int'(rnd_bit);
        m_pos++;
      end
    end else if (m_pos == W) begin
      m_smp = m_val;
      m_prs = (m_val < int'(level));
      m_pos++;
    end else if (m_pos == W + int'(m_prs) + C) begin
      if (enable) begin
        m_pos = 0; m_val = 0;
      end else begin
        m_act = 1'b0;
      end
    end else begin
      m_pos++;
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int npress = 0;
  int c0 = 0;
  int pe[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    chk("press", 32'(press), 32'(m_act && m_prs && (m_pos == W + 1)));
    chk("busy",  32'(busy),  32'(m_act));
    chk("sample", 32'(sample), 32'(m_smp));
    if (press === 1'b1) begin
      npress++;
      pe.push_back(cyc - c0 - 1);
    end
  endtask

  task automatic run_period(input string nm);
    enable = 1'b1; rnd_bit = 1'b0; level = 10'h001;
    c0 = cyc;
    pe.delete();
    repeat (45) step();
    chk({nm, "_npulses"}, 32'(pe.size()), 32'd3);
    chk({nm, "_edge0"}, 32'(pe.size() > 0 ? pe[0] : -1), 32'd11);
    chk({nm, "_edge1"}, 32'(pe.size() > 1 ? pe[1] : -1), 32'd26);
    chk({nm, "_edge2"}, 32'(pe.size() > 2 ? pe[2] : -1), 32'd41);
    chk({nm, "_sample"}, 32'(sample), 32'h000);
    enable = 1'b0;
    repeat (20) step();
  endtask

  task automatic run_pattern(input string nm, input logic [W-1:0] pat, input logic [W-1:0] lv,
                             input int exp_np, input logic [W-1:0] exp_smp);
    int np0;
    np0 = npress;
    level = lv;
    enable = 1'b1;
    step();
    for (int i = 0; i < W; i++) begin
      rnd_bit = pat[W-1-i];
      step();
    end
    enable = 1'b0;
    rnd_bit = 1'b0;
    repeat (8) step();
    chk({nm, "_presses"}, 32'(npress - np0), 32'(exp_np));
    chk({nm, "_sample"}, 32'(sample), 32'(exp_smp));
  endtask

  task automatic async_reset(input string nm);
    #2 reset = 1'b1;
    #1;
    chk({nm, "_press"}, 32'(press), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_sample"}, 32'(sample), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    enable = 1'b0;
  endtask

  initial begin
    int np0;
    int busy_low;
    reset = 1'b1; enable = 1'b0; rnd_bit = 1'b0; level = '0;
    #1;
    chk("rst_press", 32'(press), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sample", 32'(sample), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) step();

    run_period("period");

    run_pattern("pat_2ab", 10'h2AA, 10'h2AB, 1, 10'h2AA);
    run_pattern("pat_2aa", 10'h2AA, 10'h2AA, 0, 10'h2AA);

    // All-ones samples against an all-ones threshold never press.
    np0 = npress; busy_low = 0;
    rnd_bit = 1'b1; level = 10'h3FF; enable = 1'b1;
    step();
    repeat (100) begin
      step();
      if (busy !== 1'b1) busy_low++;
    end
    chk("ones_presses", 32'(npress - np0), 32'd0);
    chk("ones_busy_low", 32'(busy_low), 32'd0);
    chk("ones_sample", 32'(sample), 32'h3FF);
    enable = 1'b0;
    repeat (20) step();

    // Abort after five captured bits.
    np0 = npress;
    enable = 1'b1;
    step();
    repeat (5) begin
      rnd_bit = 1'($urandom);
      step();
    end
    enable = 1'b0;
    step();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sample", 32'(sample), 32'h3FF);
    repeat (10) step();
    chk("abort_presses", 32'(npress - np0), 32'd0);

    // Threshold raised while deciding takes effect.
    rnd_bit = 1'b0; level = 10'h000; enable = 1'b1;
    step();
    repeat (W) step();
    level = 10'h3FF;
    enable = 1'b0;
    step();
    chk("late_level_press", 32'(press), 32'd1);
    repeat (8) step();

    // Asynchronous reset mid-FILL of a second run, then mid-COOL.
    rnd_bit = 1'b1; level = 10'h3FF; enable = 1'b1;
    step();
    repeat (W + 1 + C + 4) step();
    chk("prefill_sample", 32'(sample), 32'h3FF);
    async_reset("rst_fill");
    repeat (3) step();
    rnd_bit = 1'b1; level = 10'h3FF; enable = 1'b1;
    step();
    repeat (W + 2) step();
    chk("precool_busy", 32'(busy), 32'd1);
    async_reset("rst_cool");
    repeat (3) step();
    run_period("period_after_rst");

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 19) != 0);
      rnd_bit = 1'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0: level = 10'h000;
          1: level = 10'h3FF;
          default: level = W'($urandom);
        endcase
      end
      if ($urandom_range(0, 399) == 0) begin
        #2 reset = 1'b1;
        #1 reset = 1'b0;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
